// File: rtl/sum_display_pkg.sv
// Shared constants for the two-digit sum display driver.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package sum_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic DIG_UNITS = 1'b0;
    localparam logic DIG_TENS  = 1'b1;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Codes 10..15 decode to a blank digit.
module seg7_decoder
    import sum_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sum_display_driver.sv
// Latches the adder sum and multiplexes it onto a 2-digit 7-segment display.
// Define LEADING_ZERO_BLANK_EN to blank the tens digit for sums below 10.
module sum_display_driver
    import sum_display_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] S,
    input  logic       sum_valid,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_start
);

    localparam int            CW      = clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]    AN_OFF  = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [CW-1:0] cnt;
    logic          digit_sel;
    logic [4:0]    pending;
    logic [4:0]    shadow;
    logic          wrap;
    logic          boundary;
    logic [1:0]    tens;
    logic [4:0]    ten_off;
    logic [3:0]    units;
    logic [3:0]    digit;
    logic [6:0]    pattern;
    logic [6:0]    lit;
    logic [1:0]    an_on;

    assign wrap     = (cnt == CNT_MAX);
    assign boundary = wrap && (digit_sel == DIG_TENS);

    // Range compare instead of divide: the sum never exceeds 31.
    always_comb begin
        tens    = 2'd0;
        ten_off = 5'd0;
        if (shadow >= 5'd30) begin
            tens    = 2'd3;
            ten_off = 5'd30;
        end else if (shadow >= 5'd20) begin
            tens    = 2'd2;
            ten_off = 5'd20;
        end else if (shadow >= 5'd10) begin
            tens    = 2'd1;
            ten_off = 5'd10;
        end
        units = 4'(shadow - ten_off);
    end

    assign digit = (digit_sel == DIG_TENS) ? {2'b00, tens} : units;

    seg7_decoder u_dec (
        .digit   (digit),
        .pattern (pattern)
    );

    always_comb begin
        lit = pattern;
`ifdef LEADING_ZERO_BLANK_EN
        if ((digit_sel == DIG_TENS) && (tens == 2'd0)) lit = SEG_BLANK;
`else
        lit = pattern;
`endif
    end

    always_comb begin
        an_on            = 2'b00;
        an_on[digit_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            digit_sel   <= DIG_UNITS;
            pending     <= 5'd0;
            shadow      <= 5'd0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) digit_sel <= ~digit_sel;
            if (sum_valid) pending <= S;
            // Shadow only moves at a frame edge so a frame never mixes two sums.
            if (boundary) shadow <= pending;
            frame_start <= boundary;
            seg <= SEG_ACTIVE_LOW ? ~lit : lit;
            an  <= AN_ACTIVE_LOW ? ~an_on : an_on;
        end
    end

endmodule
